// File: rtl/state_machine_race.sv
// rtl/state_machine_race.sv - sequential 7-digit code-entry checker with 7-segment progress display
module state_machine_race (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] numero,
  input  logic       insere,
  output logic       led,
  output logic [6:0] display
);

  typedef enum logic [3:0] {
    S0   = 4'd0,
    S1   = 4'd1,
    S2   = 4'd2,
    S3   = 4'd3,
    S4   = 4'd4,
    S5   = 4'd5,
    S6   = 4'd6,
    OPEN = 4'd7,
    ERR  = 4'd8
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       insere_q;
  logic       acc;
  logic [3:0] expected_digit;

  assign acc = insere & ~insere_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S0;
      insere_q <= 1'b0;
    end else begin
      state    <= state_next;
      insere_q <= insere;
    end
  end

  // Secret code 5-3-7-9-5-2-9, indexed by the number of digits already matched.
  always_comb begin
    expected_digit = 4'd0;
    case (state)
      S0:      expected_digit = 4'd5;
      S1:      expected_digit = 4'd3;
      S2:      expected_digit = 4'd7;
      S3:      expected_digit = 4'd9;
      S4:      expected_digit = 4'd5;
      S5:      expected_digit = 4'd2;
      S6:      expected_digit = 4'd9;
      default: expected_digit = 4'd0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (acc) begin
      case (state)
        S0:      state_next = (numero == expected_digit) ? S1   : ERR;
        S1:      state_next = (numero == expected_digit) ? S2   : ERR;
        S2:      state_next = (numero == expected_digit) ? S3   : ERR;
        S3:      state_next = (numero == expected_digit) ? S4   : ERR;
        S4:      state_next = (numero == expected_digit) ? S5   : ERR;
        S5:      state_next = (numero == expected_digit) ? S6   : ERR;
        S6:      state_next = (numero == expected_digit) ? OPEN : ERR;
        OPEN:    state_next = OPEN;
        ERR:     state_next = ERR;
        default: state_next = ERR;
      endcase
    end
  end

  // Moore decode; segments are {g,f,e,d,c,b,a}, active-high.
  always_comb begin
    led     = 1'b0;
    display = 7'b1111001;
    case (state)
      S0:      display = 7'b0111111;
      S1:      display = 7'b0000110;
      S2:      display = 7'b1011011;
      S3:      display = 7'b1001111;
      S4:      display = 7'b1100110;
      S5:      display = 7'b1101101;
      S6:      display = 7'b1111101;
      OPEN: begin
        display = 7'b0000111;
        led     = 1'b1;
      end
      default: display = 7'b1111001;
    endcase
  end

endmodule

// File: tb/tb_state_machine_race.sv
// tb/tb_state_machine_race.sv - directed self-checking bench for state_machine_race
module tb_state_machine_race;

  logic       clk;
  logic       reset;
  logic [3:0] numero;
  logic       insere;
  logic       led;
  logic [6:0] display;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_E = 7'b1111001;

  state_machine_race dut (
    .clk     (clk),
    .reset   (reset),
    .numero  (numero),
    .insere  (insere),
    .led     (led),
    .display (display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Hold insere high for n edges, then low for one edge; returns at a negedge.
  task automatic insert(input logic [3:0] d, input int n);
    numero = d;
    insere = 1'b1;
    repeat (n) @(negedge clk);
    insere = 1'b0;
    numero = 4'd0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    numero = 4'd0;
    insere = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_display", display, SEG_0);
    check("reset_led", {6'd0, led}, 7'd0);

    // Error path: 5,3,7,9 then 12, then 5,9 ignored
    insert(4'd5, 1); check("e_after5", display, SEG_1);
    insert(4'd3, 1); check("e_after3", display, SEG_2);
    insert(4'd7, 1); check("e_after7", display, SEG_3);
    insert(4'd9, 1); check("e_after9", display, SEG_4);
    insert(4'd12, 1); check("e_after12", display, SEG_E);
    check("e_led", {6'd0, led}, 7'd0);
    insert(4'd5, 1); check("e_absorb5", display, SEG_E);
    insert(4'd9, 1); check("e_absorb9", display, SEG_E);

    // Full correct code
    do_reset();
    check("rst_from_err", display, SEG_0);
    insert(4'd5, 1); check("ok_d1", display, SEG_1);
    insert(4'd3, 1); check("ok_d2", display, SEG_2);
    insert(4'd7, 1); check("ok_d3", display, SEG_3);
    insert(4'd9, 1); check("ok_d4", display, SEG_4);
    insert(4'd5, 1); check("ok_d5", display, SEG_5);
    insert(4'd2, 1); check("ok_d6", display, SEG_6);
    check("ok_led_before_open", {6'd0, led}, 7'd0);
    insert(4'd9, 1); check("ok_open_display", display, SEG_7);
    check("ok_open_led", {6'd0, led}, 7'd1);
    insert(4'd5, 1); check("open_absorb_disp", display, SEG_7);
    insert(4'd0, 1); check("open_absorb_led", {6'd0, led}, 7'd1);

    // Reset from OPEN, then 5,3,2,1
    do_reset();
    check("rst_open_led", {6'd0, led}, 7'd0);
    check("rst_open_disp", display, SEG_0);
    insert(4'd5, 1); check("p_d1", display, SEG_1);
    insert(4'd3, 1); check("p_d2", display, SEG_2);
    insert(4'd2, 1); check("p_err", display, SEG_E);
    insert(4'd1, 1); check("p_err_stays", display, SEG_E);

    // Held insere: one accept per rising edge
    do_reset();
    numero = 4'd5;
    insere = 1'b1;
    @(negedge clk); check("hold_edge1", display, SEG_1);
    @(negedge clk); check("hold_edge2", display, SEG_1);
    @(negedge clk); check("hold_edge3", display, SEG_1);
    insere = 1'b0;
    @(negedge clk);
    insert(4'd3, 3); check("hold_second", display, SEG_2);

    // Reset wins over a simultaneous accept; held insere re-accepts after reset
    do_reset();
    reset  = 1'b1;
    numero = 4'd5;
    insere = 1'b1;
    @(negedge clk);
    check("rst_vs_acc", display, SEG_0);
    reset = 1'b0;
    @(negedge clk);
    check("acc_after_rst", display, SEG_1);
    insere = 1'b0;
    @(negedge clk);
    check("idle_hold", display, SEG_1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
